// File: rtl/fp_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : fp_lane_packer
// Purpose  : Packs a serial FP operand-pair stream into LANES-wide groups with
//            zero padding, idle flush, one-group output buffering and a
//            delayed adder-tree enable pulse.
// Revision : 1.0
// ============================================================================
module fp_lane_packer #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 16,
    parameter int SUM_DELAY = 64,
    parameter int IDLE_MAX  = 255
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [DATA_W-1:0]       in_A,
    input  logic [DATA_W-1:0]       in_B,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic                    in_acc_sign,
    output logic [LANES*DATA_W-1:0] out_A,
    output logic [LANES*DATA_W-1:0] out_B,
    output logic [LANES-1:0]        out_mask,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    out_flush,
    output logic                    out_acc_sign,
    output logic                    sum_clock_en,
    output logic                    busy
);
    localparam int                BUS_W     = LANES * DATA_W;
    localparam int                IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LANES - 1);
    localparam logic [7:0]        IDLE_LAST = 8'(IDLE_MAX - 1);

    logic [BUS_W-1:0]     stg_a_q, stg_a_d, stg_b_q, stg_b_d;
    logic [LANES-1:0]     stg_mask_q, stg_mask_d;
    logic                 stg_sign_q, stg_sign_d;
    logic                 stg_last_q, stg_last_d;
    logic                 stg_flush_q, stg_flush_d;
    logic                 stg_closed_q, stg_closed_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           idle_q, idle_d;
    logic [BUS_W-1:0]     out_a_q, out_a_d, out_b_q, out_b_d;
    logic [LANES-1:0]     out_mask_q, out_mask_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 out_flush_q, out_flush_d;
    logic                 out_sign_q, out_sign_d;
    logic [SUM_DELAY-1:0] sum_q, sum_d;

    logic                 w_acc, w_slot_free, w_timeout, w_beat_close;
    logic                 w_close, w_xfer, w_sum_load;
    logic [BUS_W-1:0]     w_grp_a, w_grp_b;
    logic [LANES-1:0]     w_grp_mask;
    logic                 w_grp_sign, w_grp_last, w_grp_flush;

    always_comb begin
        w_acc        = in_valid & ~stg_closed_q;
        w_slot_free  = ~out_valid_q | out_ready;
        w_timeout    = (idx_q != '0) & ~stg_closed_q & ~w_acc & (idle_q == IDLE_LAST);
        w_beat_close = w_acc & (in_last | (idx_q == LAST_IDX));

        // Staging image including the beat landing on this edge.
        w_grp_a     = stg_a_q;
        w_grp_b     = stg_b_q;
        w_grp_mask  = stg_mask_q;
        w_grp_sign  = stg_sign_q;
        w_grp_last  = stg_last_q;
        w_grp_flush = stg_flush_q | w_timeout;
        if (w_acc) begin
            w_grp_a[idx_q*DATA_W +: DATA_W] = in_A;
            w_grp_b[idx_q*DATA_W +: DATA_W] = in_B;
            w_grp_mask[idx_q]               = 1'b1;
            w_grp_last                      = in_last;
            if (idx_q == '0) begin
                w_grp_sign = in_acc_sign;
            end
        end

        w_close    = stg_closed_q | w_beat_close | w_timeout;
        w_xfer     = w_close & w_slot_free;
        w_sum_load = out_valid_q & out_ready & out_last_q;

        stg_a_d      = stg_a_q;
        stg_b_d      = stg_b_q;
        stg_mask_d   = stg_mask_q;
        stg_sign_d   = stg_sign_q;
        stg_last_d   = stg_last_q;
        stg_flush_d  = stg_flush_q;
        stg_closed_d = stg_closed_q;
        idx_d        = idx_q;
        idle_d       = idle_q;

        if (w_xfer) begin
            stg_a_d      = '0;
            stg_b_d      = '0;
            stg_mask_d   = '0;
            stg_sign_d   = 1'b0;
            stg_last_d   = 1'b0;
            stg_flush_d  = 1'b0;
            stg_closed_d = 1'b0;
            idx_d        = '0;
            idle_d       = '0;
        end else if (w_close) begin
            stg_a_d      = w_grp_a;
            stg_b_d      = w_grp_b;
            stg_mask_d   = w_grp_mask;
            stg_sign_d   = w_grp_sign;
            stg_last_d   = w_grp_last;
            stg_flush_d  = w_grp_flush;
            stg_closed_d = 1'b1;
            idle_d       = '0;
        end else if (w_acc) begin
            stg_a_d      = w_grp_a;
            stg_b_d      = w_grp_b;
            stg_mask_d   = w_grp_mask;
            stg_sign_d   = w_grp_sign;
            idx_d        = idx_q + IDX_W'(1);
            idle_d       = '0;
        end else if (idx_q != '0) begin
            idle_d       = idle_q + 8'd1;
        end

        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_mask_d  = out_mask_q;
        out_last_d  = out_last_q;
        out_flush_d = out_flush_q;
        out_sign_d  = out_sign_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (w_xfer) begin
            out_a_d     = w_grp_a;
            out_b_d     = w_grp_b;
            out_mask_d  = w_grp_mask;
            out_last_d  = w_grp_last;
            out_flush_d = w_grp_flush;
            out_sign_d  = w_grp_sign;
            out_valid_d = 1'b1;
        end
    end

    generate
        if (SUM_DELAY == 1) begin : g_sum_single
            assign sum_d = w_sum_load;
        end else begin : g_sum_chain
            assign sum_d = {sum_q[SUM_DELAY-2:0], w_sum_load};
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stg_a_q      <= '0;
            stg_b_q      <= '0;
            stg_mask_q   <= '0;
            stg_sign_q   <= 1'b0;
            stg_last_q   <= 1'b0;
            stg_flush_q  <= 1'b0;
            stg_closed_q <= 1'b0;
            idx_q        <= '0;
            idle_q       <= '0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_mask_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_flush_q  <= 1'b0;
            out_sign_q   <= 1'b0;
            sum_q        <= '0;
        end else begin
            stg_a_q      <= stg_a_d;
            stg_b_q      <= stg_b_d;
            stg_mask_q   <= stg_mask_d;
            stg_sign_q   <= stg_sign_d;
            stg_last_q   <= stg_last_d;
            stg_flush_q  <= stg_flush_d;
            stg_closed_q <= stg_closed_d;
            idx_q        <= idx_d;
            idle_q       <= idle_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_mask_q   <= out_mask_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_flush_q  <= out_flush_d;
            out_sign_q   <= out_sign_d;
            sum_q        <= sum_d;
        end
    end

    assign in_ready     = ~stg_closed_q;
    assign out_A        = out_a_q;
    assign out_B        = out_b_q;
    assign out_mask     = out_mask_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_flush    = out_flush_q;
    assign out_acc_sign = out_sign_q;
    assign sum_clock_en = sum_q[SUM_DELAY-1];
    assign busy         = (|stg_mask_q) | out_valid_q | (|sum_q);

endmodule
`default_nettype wire

// File: tb/tb_fp_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_lane_packer
// Purpose  : Self-checking bench for fp_lane_packer (group table, corner
//            sequences, randomized traffic against a transaction-level model).
// Revision : 1.0
// ============================================================================
module tb_fp_lane_packer;
    localparam int DATA_W    = 32;
    localparam int LANES     = 16;
    localparam int SUM_DELAY = 4;
    localparam int IDLE_MAX  = 8;
    localparam int BW        = LANES * DATA_W;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic [DATA_W-1:0] in_A = '0, in_B = '0;
    logic              in_valid = 1'b0, in_last = 1'b0, in_acc_sign = 1'b0;
    logic              out_ready = 1'b0;
    logic              in_ready, out_valid, out_last, out_flush, out_acc_sign;
    logic              sum_clock_en, busy;
    logic [BW-1:0]     out_A, out_B;
    logic [LANES-1:0]  out_mask;

    fp_lane_packer #(
        .DATA_W(DATA_W), .LANES(LANES), .SUM_DELAY(SUM_DELAY), .IDLE_MAX(IDLE_MAX)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_A(in_A), .in_B(in_B), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_acc_sign(in_acc_sign),
        .out_A(out_A), .out_B(out_B), .out_mask(out_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_flush(out_flush),
        .out_acc_sign(out_acc_sign), .sum_clock_en(sum_clock_en), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    // Reference model: closed groups wait in a two-deep queue (presented slot
    // plus closed staging); the open group accumulates in cur.
    typedef struct packed {
        logic [BW-1:0]    a;
        logic [BW-1:0]    b;
        logic [LANES-1:0] mask;
        logic             last;
        logic             flush;
        logic             sign;
    } grp_t;

    grp_t mq[$];
    grp_t cur;
    int   n_cur, idle_cnt, cyc;
    int   pulse_q[$];

    typedef struct {
        int               nbeats;
        logic             last;
        logic             sign;
        logic [LANES-1:0] exp_mask;
        logic             exp_last;
        logic             exp_flush;
        logic             exp_sign;
        int               exp_wait;
    } vec_t;

    vec_t          vecs[5];
    logic [BW-1:0] exp_a, exp_b;
    int            wcnt, k, pulses[$];
    logic          rdy_before, r_v, r_l, r_o;
    int            mode;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pulse_q.delete();
        cur      = '0;
        n_cur    = 0;
        idle_cnt = 0;
    endtask

    task automatic model_edge();
        logic acc, hs;
        acc = in_valid && (mq.size() < 2);
        hs  = (mq.size() > 0) && out_ready;
        cyc++;
        if (hs) begin
            if (mq[0].last) pulse_q.push_back(cyc + SUM_DELAY - 1);
            void'(mq.pop_front());
        end
        if (acc) begin
            cur.a[n_cur*DATA_W +: DATA_W] = in_A;
            cur.b[n_cur*DATA_W +: DATA_W] = in_B;
            cur.mask[n_cur] = 1'b1;
            if (n_cur == 0) cur.sign = in_acc_sign;
            n_cur++;
            idle_cnt = 0;
            if (n_cur == LANES || in_last) begin
                cur.last  = in_last;
                cur.flush = 1'b0;
                mq.push_back(cur);
                cur   = '0;
                n_cur = 0;
            end
        end else if (n_cur > 0) begin
            idle_cnt++;
            if (idle_cnt == IDLE_MAX) begin
                cur.flush = 1'b1;
                mq.push_back(cur);
                cur      = '0;
                n_cur    = 0;
                idle_cnt = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic exp_sum, exp_busy;
        while (pulse_q.size() > 0 && pulse_q[0] < cyc) void'(pulse_q.pop_front());
        exp_sum  = (pulse_q.size() > 0) && (pulse_q[0] == cyc);
        exp_busy = (n_cur > 0) || (mq.size() > 0) || (pulse_q.size() > 0);
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk_bus("out_A", out_A, mq[0].a);
            chk_bus("out_B", out_B, mq[0].b);
            chk("out_mask", 64'(out_mask), 64'(mq[0].mask));
            chk("out_last", 64'(out_last), 64'(mq[0].last));
            chk("out_flush", 64'(out_flush), 64'(mq[0].flush));
            chk("out_acc_sign", 64'(out_acc_sign), 64'(mq[0].sign));
        end
        chk("sum_clock_en", 64'(sum_clock_en), 64'(exp_sum));
        chk("busy", 64'(busy), 64'(exp_busy));
    endtask

    task automatic cycle(input logic v, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic last, input logic sign, input logic ordy);
        in_valid    = v;
        in_A        = a;
        in_B        = b;
        in_last     = last;
        in_acc_sign = sign;
        out_ready   = ordy;
        model_edge();
        @(posedge aclk);
        @(negedge aclk);
        check_outputs();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy);
    endtask

    task automatic apply_reset();
        aresetn     = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_acc_sign = 1'b0;
        out_ready   = 1'b0;
        model_reset();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk_bus("rst_out_A", out_A, '0);
        chk_bus("rst_out_B", out_B, '0);
        chk("rst_out_mask", 64'(out_mask), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_flush", 64'(out_flush), 64'd0);
        chk("rst_out_acc_sign", 64'(out_acc_sign), 64'd0);
        chk("rst_sum_clock_en", 64'(sum_clock_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{5,  1'b1, 1'b1, 16'h001F, 1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{3,  1'b0, 1'b0, 16'h0007, 1'b0, 1'b1, 1'b0, IDLE_MAX};
        vecs[3] = '{1,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{16, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0};
        cyc = 0;
        model_reset();

        @(negedge aclk);
        apply_reset();

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < vecs[t].nbeats; i++)
                cycle(1'b1, DATA_W'(i), DATA_W'(32'h100 + i),
                      vecs[t].last && (i == vecs[t].nbeats - 1), vecs[t].sign && (i == 0), 1'b1);
            wcnt = 0;
            while (!out_valid && wcnt < 20) begin
                idle(1'b0);
                wcnt++;
            end
            checks++;
            if (!out_valid) begin
                failures++;
                $display("FAIL vec%0d_group_timeout: got out_valid=0 expected 1 within 20 cycles", t);
            end else begin
                exp_a = '0;
                exp_b = '0;
                for (int i = 0; i < vecs[t].nbeats; i++) begin
                    exp_a[i*DATA_W +: DATA_W] = DATA_W'(i);
                    exp_b[i*DATA_W +: DATA_W] = DATA_W'(32'h100 + i);
                end
                chk_bus($sformatf("vec%0d_out_A", t), out_A, exp_a);
                chk_bus($sformatf("vec%0d_out_B", t), out_B, exp_b);
                chk($sformatf("vec%0d_mask", t), 64'(out_mask), 64'(vecs[t].exp_mask));
                chk($sformatf("vec%0d_last", t), 64'(out_last), 64'(vecs[t].exp_last));
                chk($sformatf("vec%0d_flush", t), 64'(out_flush), 64'(vecs[t].exp_flush));
                chk($sformatf("vec%0d_sign", t), 64'(out_acc_sign), 64'(vecs[t].exp_sign));
                chk($sformatf("vec%0d_wait", t), 64'(wcnt), 64'(vecs[t].exp_wait));
            end
            repeat (SUM_DELAY + 4) idle(1'b1);
        end

        // Back-pressure: 40 offered beats with the output stalled.
        k = 0;
        for (int c = 0; c < 40; c++) begin
            rdy_before = in_ready;
            cycle(1'b1, DATA_W'(1000 + k), DATA_W'(2000 + k), 1'b0, 1'b0, 1'b0);
            if (rdy_before) k++;
        end
        chk("bp_accepted", 64'(k), 64'd32);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        idle(1'b1);
        idle(1'b1);
        for (int c = 32; c < 40; c++)
            cycle(1'b1, DATA_W'(1000 + c), DATA_W'(2000 + c), c == 39, 1'b0, 1'b1);
        repeat (SUM_DELAY + 6) idle(1'b1);

        // Two last-groups handshaked two cycles apart.
        pulses.delete();
        cycle(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) cycle(1'b1, 32'h4040_0000, 32'h4080_0000, 1'b1, 1'b0, 1'b1);
            else        idle(1'b1);
            if (sum_clock_en) pulses.push_back(cyc);
        end
        chk("b2b_pulse_count", 64'(pulses.size()), 64'd2);
        if (pulses.size() == 2) chk("b2b_pulse_gap", 64'(pulses[1] - pulses[0]), 64'd2);

        // Reset with a partial group and a pending sum pulse.
        cycle(1'b1, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b1, 32'h5, 32'h6, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h7, 32'h8, 1'b0, 1'b0, 1'b1);
        apply_reset();
        k = 0;
        for (int c = 0; c < SUM_DELAY + 6; c++) begin
            idle(1'b0);
            if (sum_clock_en) k++;
        end
        chk("rst_no_late_pulse", 64'(k), 64'd0);
        cycle(1'b1, 32'hABCD, 32'h1234, 1'b1, 1'b0, 1'b0);
        chk("rst_next_mask", 64'(out_mask), 64'h1);
        chk("rst_next_lane0", 64'(out_A[DATA_W-1:0]), 64'hABCD);
        repeat (SUM_DELAY + 4) idle(1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            mode = (c / 50) % 3;
            r_v  = (mode == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 7);
            r_o  = (mode == 1) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
            r_l  = ($urandom_range(0, 11) == 0);
            cycle(r_v, $urandom, $urandom, r_l, 1'($urandom_range(0, 1)), r_o);
        end
        repeat (30) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
